// File: rtl/demodchest_seq_pkg.sv
// Shared types and register map for the demodchest packet sequencer.
// The optional timed start is enabled by defining DEMODCHEST_SEQ_TIMED_START_EN.
package demodchest_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_TIME = 3'd2,
        RUN       = 3'd3,
        STOPPING  = 3'd4
    } seq_state_t;

    localparam logic [19:0] REG_CMD      = 20'h00;
    localparam logic [19:0] REG_NUM_PKTS = 20'h04;
    localparam logic [19:0] REG_START_LO = 20'h08;
    localparam logic [19:0] REG_START_HI = 20'h0C;
    localparam logic [19:0] REG_STATUS   = 20'h10;

    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;
    localparam int CMD_CONT  = 2;

    function automatic logic [31:0] pack_status(input logic [2:0]  state_bits,
                                                input logic [7:0]  late_cnt,
                                                input logic [15:0] run_cnt);
        return {run_cnt, late_cnt, 5'd0, state_bits};
    endfunction

endpackage

// File: rtl/demodchest_seq_regs.sv
// CtrlPort register slave for the sequencer: decode, storage, one-cycle ack, command pulses.
// START_TIME storage exists only when DEMODCHEST_SEQ_TIMED_START_EN is defined.
module demodchest_seq_regs
    import demodchest_seq_pkg::*;
#(
    parameter logic [19:0] CTRL_BASE = 20'h00000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_wr,
    input  logic             req_rd,
    input  logic [19:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             resp_ack,
    output logic [31:0]      resp_data,
    input  logic [2:0]       state_bits,
    input  logic [7:0]       late_cnt,
    input  logic [CNT_W-1:0] run_cnt,
    output logic [CNT_W-1:0] num_pkts,
    output logic             cont,
    output logic [63:0]      start_time,
    output logic             start_pulse,
    output logic             stop_pulse
);

    localparam logic [19:0] ADDR_CMD      = CTRL_BASE + REG_CMD;
    localparam logic [19:0] ADDR_NUM_PKTS = CTRL_BASE + REG_NUM_PKTS;
    localparam logic [19:0] ADDR_START_LO = CTRL_BASE + REG_START_LO;
    localparam logic [19:0] ADDR_START_HI = CTRL_BASE + REG_START_HI;
    localparam logic [19:0] ADDR_STATUS   = CTRL_BASE + REG_STATUS;

    logic [31:0] rd_val;
    logic        unused_data;

    assign unused_data = ^req_data;

    // STOP in the same write as START suppresses the START pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_pkts    <= '0;
            cont        <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            resp_ack    <= 1'b0;
            resp_data   <= '0;
        end else begin
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            resp_ack    <= req_wr | req_rd;
            resp_data   <= req_rd ? rd_val : 32'd0;
            if (req_wr) begin
                if (req_addr == ADDR_CMD) begin
                    cont        <= req_data[CMD_CONT];
                    start_pulse <= req_data[CMD_START] & ~req_data[CMD_STOP];
                    stop_pulse  <= req_data[CMD_STOP];
                end
                if (req_addr == ADDR_NUM_PKTS) begin
                    num_pkts <= req_data[CNT_W-1:0];
                end
            end
        end
    end

`ifdef DEMODCHEST_SEQ_TIMED_START_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_time <= '0;
        end else if (req_wr) begin
            if (req_addr == ADDR_START_LO) start_time[31:0]  <= req_data;
            if (req_addr == ADDR_START_HI) start_time[63:32] <= req_data;
        end
    end
`else
    assign start_time = 64'd0;
`endif

    always_comb begin
        rd_val = 32'd0;
        case (req_addr)
            ADDR_NUM_PKTS: rd_val[CNT_W-1:0] = num_pkts;
            ADDR_START_LO: rd_val = start_time[31:0];
            ADDR_START_HI: rd_val = start_time[63:32];
            ADDR_STATUS:   rd_val = pack_status(state_bits, late_cnt, 16'(run_cnt));
            default:       rd_val = 32'd0;
        endcase
    end

endmodule

// File: rtl/demodchest_seq.sv
// Packet-granular frame sequencer: discards input until armed, then passes whole packets.
// Define DEMODCHEST_SEQ_TIMED_START_EN to wait for a start timestamp before running.
module demodchest_seq
    import demodchest_seq_pkg::*;
#(
    parameter logic [19:0] CTRL_BASE = 20'h00000,
    parameter int          ITEM_W    = 32,
    parameter int          CNT_W     = 16
) (
    input  logic              axis_data_clk,
    input  logic              axis_data_rst_n,
    input  logic              s_ctrlport_req_wr,
    input  logic              s_ctrlport_req_rd,
    input  logic [19:0]       s_ctrlport_req_addr,
    input  logic [31:0]       s_ctrlport_req_data,
    output logic              s_ctrlport_resp_ack,
    output logic [31:0]       s_ctrlport_resp_data,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [63:0]       s_axis_ttimestamp,
    input  logic              s_axis_thas_time,
    input  logic              s_axis_teov,
    input  logic              s_axis_teob,
    input  logic [15:0]       s_axis_tlength,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [63:0]       m_axis_ttimestamp,
    output logic              m_axis_thas_time,
    output logic              m_axis_teov,
    output logic              m_axis_teob,
    output logic [15:0]       m_axis_tlength,
    output logic              busy
);

`ifdef DEMODCHEST_SEQ_TIMED_START_EN
    localparam seq_state_t START_TARGET = WAIT_TIME;
`else
    localparam seq_state_t START_TARGET = ARM;
`endif

    seq_state_t       state, next_state;
    logic [2:0]       state_bits;
    logic             sop, pass_r, eob_r;
    logic             accept, pass_now, eob_now, pass, force_eob;
    logic             hs, sop_hs, tlast_hs, time_ok, start_ok;
    logic [CNT_W-1:0] run_cnt, cnt_inc, num_pkts;
    logic [7:0]       late_cnt;
    logic [63:0]      start_time;
    logic             cont, start_pulse, stop_pulse;

    demodchest_seq_regs #(
        .CTRL_BASE (CTRL_BASE),
        .CNT_W     (CNT_W)
    ) u_regs (
        .clk         (axis_data_clk),
        .rst_n       (axis_data_rst_n),
        .req_wr      (s_ctrlport_req_wr),
        .req_rd      (s_ctrlport_req_rd),
        .req_addr    (s_ctrlport_req_addr),
        .req_data    (s_ctrlport_req_data),
        .resp_ack    (s_ctrlport_resp_ack),
        .resp_data   (s_ctrlport_resp_data),
        .state_bits  (state_bits),
        .late_cnt    (late_cnt),
        .run_cnt     (run_cnt),
        .num_pkts    (num_pkts),
        .cont        (cont),
        .start_time  (start_time),
        .start_pulse (start_pulse),
        .stop_pulse  (stop_pulse)
    );

    assign state_bits = state;
    assign hs         = s_axis_tvalid & s_axis_tready;
    assign sop_hs     = hs & sop;
    assign tlast_hs   = hs & s_axis_tlast;
    assign cnt_inc    = run_cnt + 1'b1;
    assign time_ok    = s_axis_thas_time & (s_axis_ttimestamp >= start_time);
    assign start_ok   = start_pulse & ((num_pkts != '0) | cont);

    always_ff @(posedge axis_data_clk) begin
        if (!axis_data_rst_n) state <= IDLE;
        else                  state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_ok) next_state = START_TARGET;
            end
            ARM, WAIT_TIME: begin
                if (stop_pulse)            next_state = IDLE;
                else if (sop_hs && accept) next_state = (tlast_hs && eob_now) ? IDLE : RUN;
            end
            RUN: begin
                if (stop_pulse && sop)          next_state = IDLE;
                else if (tlast_hs && force_eob) next_state = IDLE;
                else if (stop_pulse)            next_state = STOPPING;
            end
            STOPPING: begin
                if (tlast_hs) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Decisions are combinational on the sop beat and held in pass_r/eob_r for the rest.
    always_comb begin
        accept = 1'b0;
        if (!stop_pulse) begin
            if (state == ARM)            accept = 1'b1;
            else if (state == WAIT_TIME) accept = time_ok;
        end
        pass_now  = sop & (accept | ((state == RUN) & ~stop_pulse));
        eob_now   = pass_now & ~cont & (cnt_inc == num_pkts);
        pass      = sop ? pass_now : pass_r;
        force_eob = sop ? eob_now : (eob_r | (stop_pulse & (state == RUN)));
    end

    always_ff @(posedge axis_data_clk) begin
        if (!axis_data_rst_n) begin
            sop     <= 1'b1;
            pass_r  <= 1'b0;
            eob_r   <= 1'b0;
            run_cnt <= '0;
        end else begin
            if (hs) sop <= s_axis_tlast;
            if (sop_hs) begin
                pass_r <= pass_now;
                eob_r  <= eob_now;
            end else if (stop_pulse && (state == RUN)) begin
                eob_r <= 1'b1;
            end
            if (tlast_hs) begin
                pass_r <= 1'b0;
                eob_r  <= 1'b0;
            end
            if ((state == IDLE) && start_ok) run_cnt <= '0;
            else if (tlast_hs && pass)       run_cnt <= cnt_inc;
        end
    end

`ifdef DEMODCHEST_SEQ_TIMED_START_EN
    // A start whose first packet is stamped after START_TIME is recorded as late.
    always_ff @(posedge axis_data_clk) begin
        if (!axis_data_rst_n) begin
            late_cnt <= 8'd0;
        end else if ((state == WAIT_TIME) && sop_hs && accept &&
                     (s_axis_ttimestamp > start_time) && (late_cnt != 8'hFF)) begin
            late_cnt <= late_cnt + 8'd1;
        end
    end
`else
    assign late_cnt = 8'd0;
`endif

    assign m_axis_tdata      = s_axis_tdata;
    assign m_axis_tlast      = s_axis_tlast;
    assign m_axis_ttimestamp = s_axis_ttimestamp;
    assign m_axis_thas_time  = s_axis_thas_time;
    assign m_axis_teov       = s_axis_teov;
    assign m_axis_tlength    = s_axis_tlength;
    assign m_axis_teob       = s_axis_teob | (pass & force_eob);
    assign m_axis_tvalid     = s_axis_tvalid & pass;
    assign s_axis_tready     = pass ? m_axis_tready : 1'b1;
    assign busy              = (state != IDLE);

endmodule

// File: doc/demodchest_seq.md
# demodchest_seq

Packet-granular frame sequencer between the demodchest NoC shell's input stream (`m_in_axis_*`) and the demod/channel-estimation core. It discards incoming packets until armed by a CtrlPort write, optionally waits for a start timestamp, then passes exactly NUM_PKTS whole packets (or runs continuously), marking EOB on the last one. It is also the CtrlPort register slave for sequencing control and status.

## Interface
**Parameters**
- `CTRL_BASE`, default 20'h00000: CtrlPort byte base address of the register window.
- `ITEM_W`, default 32: sample width; tdata width is ITEM_W.
- `CNT_W`, default 16: width of the packet-count register and counters.

**Ports**
- `axis_data_clk`, in, 1: single clock for CtrlPort and AXIS.
- `axis_data_rst_n`, in, 1: synchronous, active-low reset.
- `s_ctrlport_req_wr`, `s_ctrlport_req_rd`, in, 1 each: request strobes.
- `s_ctrlport_req_addr`, in, 20; `s_ctrlport_req_data`, in, 32.
- `s_ctrlport_resp_ack`, out, 1; `s_ctrlport_resp_data`, out, 32.
- `s_axis_tdata`, in, ITEM_W; `s_axis_tlast/tvalid`, in, 1; `s_axis_tready`, out, 1.
- `s_axis_ttimestamp`, in, 64; `s_axis_thas_time/teov/teob`, in, 1; `s_axis_tlength`, in, 16.
- `m_axis_*`: same set as `s_axis_*` with directions reversed.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- Registers are 32-bit, at byte offsets from CTRL_BASE:
  - 0x00 CMD (write-only): bit0 START, bit1 STOP, bit2 CONT. CONT is latched; START and STOP are one-cycle pulses.
  - 0x04 NUM_PKTS, [CNT_W-1:0].
  - 0x08 / 0x0C START_TIME lo / hi.
  - 0x10 STATUS (read-only): [2:0] state, [15:8] late count (saturating), [31:16] packets passed in the current run.
- Unmapped reads return 0. Writes to unmapped addresses are ignored.
- `sop` register: reset value 1; cleared on any input beat handshake; set on a handshake with tlast. All state decisions are taken on the beat where sop=1.
- States:
  - IDLE: discard packets.
    - START with NUM_PKTS≠0 or CONT=1 → WAIT_TIME (macro on) or ARM (macro off).
    - START with NUM_PKTS=0 and CONT=0 is ignored.
  - WAIT_TIME: at sop with thas_time=1 and ttimestamp ≥ START_TIME → RUN, and that packet passes. Otherwise discard the packet.
  - ARM: at the next sop → RUN, and that packet passes.
  - RUN: pass the packet.
    - On the tlast handshake, increment the count.
    - If CONT=0 and count+1 = NUM_PKTS: force m_axis_teob=1 on that packet's beats and go to IDLE after tlast.
  - STOPPING: finish the current packet with teob forced to 1, then go to IDLE.
- STOP:
  - IDLE/ARM/WAIT_TIME → IDLE immediately.
  - RUN at sop → IDLE, and the packet is discarded.
  - RUN mid-packet → STOPPING.
- START and STOP in the same write: STOP wins. START outside IDLE is ignored.
- Late start: on the WAIT_TIME→RUN transition, if ttimestamp > START_TIME, increment the late count. The packet still passes.
- The run counter clears on START.

## Timing
- Datapath is combinational, zero latency:
  - m_axis_tvalid = s_axis_tvalid & pass.
  - s_axis_tready = pass ? m_axis_tready : 1.
  - All sideband signals pass through unchanged, except teob, which is OR'd with the forced EOB.
- The pass decision for a packet is combinational on its sop beat, then held in a register until its tlast.
- CtrlPort: resp_ack is asserted exactly one cycle after a wr or rd strobe, for every address. A command takes effect in the cycle after the strobe.
- Reset values: all outputs 0, except s_axis_tready=1 (discard). State IDLE, sop=1, all registers 0, CONT=0.
- Reset mid-packet: the output packet is truncated. This is acceptable because the shell resets both sides together.
- The 64-bit comparison is unsigned. The counter wraps at 2^CNT_W and the late count saturates at 255.

## Configuration
- `DEMODCHEST_SEQ_TIMED_START_EN` defined:
  - WAIT_TIME is used.
  - START_TIME registers exist.
  - The late count is active.
- Not defined:
  - START goes to ARM.
  - 0x08/0x0C read 0 and ignore writes.
  - The late-count field reads 0.

## Structure
- Package `demodchest_seq_pkg`: state enum (IDLE, ARM, WAIT_TIME, RUN, STOPPING), register offset localparams, CMD bit indices.
- One sub-module, `demodchest_seq_regs`: CtrlPort decode, register storage, one-cycle ack, command pulses. The FSM and datapath gating stay in the top level.

## Test plan
- Idle discard: 3 packets of 8 beats with m_tready=1 → m_tvalid never asserted, s_tready constantly 1.
- Counted run: NUM_PKTS=2, START written mid-packet → that packet dropped; next 2 packets pass, teob=1 on all beats of the 2nd; STATUS count=2; state returns to IDLE.
- Timed start (macro on): START_TIME=1000, packets stamped 900/1000/1100, NUM_PKTS=1 → only the 1000 packet passes, late count=0. Repeat with stamps 900/1100 → the 1100 packet passes, late count=1.
- STOP mid-packet in CONT mode → current packet completes with teob=1, then IDLE. STOP+START in the same write → stays IDLE.
- Backpressure: m_tready toggling randomly during RUN → no beat lost or duplicated; s_tready equals m_tready.
- CtrlPort: read of unmapped 0x40 → ack one cycle later with data 0. NUM_PKTS=0 with CONT=0 and START → busy stays 0.
